// File: rtl/uram_pkg.sv
// Shared definitions for the UltraRAM-style simple-dual-port memory.
// Holds the collision-mode encodings, the controller state type and the
// helper that derives the write-strobe lane count from the word geometry.
package uram_pkg;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  function automatic int num_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/uram_read_pipe.sv
// Valid/data delay line placed behind the array read register.
// Each stage passes its valid bit on every cycle so bubbles propagate,
// while the data register of a stage loads only when the incoming valid is
// set; the last stage therefore holds the most recent read word.
// Ports:
//   clock     - single clock
//   reset_n   - asynchronous active-low clear of valids and data
//   vld_in    - valid entering the line
//   data_in   - data entering the line
//   vld_out   - valid leaving the last stage
//   data_out  - data held in the last stage
module uram_read_pipe
  import uram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  vld_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  vld_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DEPTH-1:0]      vld_pn;
  logic [DATA_WIDTH-1:0] data_pn [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pn <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_pn[i] <= '0;
      end
    end else begin
      // stage 0 <- array read register
      vld_pn[0] <= vld_in;
      if (vld_in) begin
        data_pn[0] <= data_in;
      end
      // stage i <- stage i-1
      for (int i = 1; i < DEPTH; i++) begin
        vld_pn[i] <= vld_pn[i-1];
        if (vld_pn[i-1]) begin
          data_pn[i] <= data_pn[i-1];
        end
      end
    end
  end

  assign vld_out  = vld_pn[DEPTH-1];
  assign data_out = data_pn[DEPTH-1];

endmodule

// File: rtl/uram_sdpram_pipelined.sv
// Simple-dual-port UltraRAM-style memory with one write port and one read
// port on a common clock. Features byte-strobed writes, configurable read
// latency (1..4), read_first / write_first collision handling, a read-valid
// strobe and an optional zero-fill sweep of the whole array after reset.
// Ports:
//   clock    - single clock
//   reset_n  - asynchronous active-low reset (control and output registers)
//   ready    - both ports accept requests (low during the zero-fill sweep)
//   ren      - read request, raddr - read address
//   rvalid   - dout carries a read result this cycle, dout - read data
//   wen      - write request, wstrb - per-lane write enable
//   waddr    - write address, din - write data
module uram_sdpram_pipelined
  import uram_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12,
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_MODE    = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                                           clock,
  input  logic                                           reset_n,
  output logic                                           ready,
  input  logic                                           ren,
  input  logic [ADDRESS_WIDTH-1:0]                       raddr,
  output logic                                           rvalid,
  output logic [DATA_WIDTH-1:0]                          dout,
  input  logic                                           wen,
  input  logic [num_lanes(DATA_WIDTH, BYTE_WIDTH)-1:0]   wstrb,
  input  logic [ADDRESS_WIDTH-1:0]                       waddr,
  input  logic [DATA_WIDTH-1:0]                          din
);

  localparam int NUM_LANES = num_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH     = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state;
  logic [ADDRESS_WIDTH-1:0] init_addr;
  logic                    rd_fire;
  logic                    wr_fire;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    vld_p0;
  logic [DATA_WIDTH-1:0]   data_p0;

  // User requests are only honoured once the controller reports ready.
  assign rd_fire = ready & ren;
  assign wr_fire = ready & wen;

  // Controller: zero-fill sweep, then normal operation. ready is registered
  // and rises on the same edge that leaves INIT; init_addr wraps back to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= (INIT_ON_RESET != 0) ? INIT : RUN;
      init_addr <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_addr <= init_addr + ADDRESS_WIDTH'(1);
          if (init_addr == LAST_ADDR) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Array write port: the sweep owns the port while in INIT. The array has
  // no reset; reset_n only keeps the sweep from writing while held.
  always_ff @(posedge clock) begin
    if (state == INIT && reset_n) begin
      mem[init_addr] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Same-cycle collision: in write_first mode the strobed lanes of din are
  // forwarded over the pre-write word; read_first just returns the old word.
  always_comb begin
    rd_word = mem[raddr];
    if (WRITE_MODE == WRITE_FIRST && wr_fire && (waddr == raddr)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wstrb[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // p0: array read register, loads only on an accepted read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) begin
        data_p0 <= rd_word;
      end
    end
  end

  // p1..: remaining READ_LATENCY-1 output stages
  if (READ_LATENCY > 1) begin : g_pipe
    uram_read_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (READ_LATENCY - 1)
    ) u_read_pipe (
      .clock    (clock),
      .reset_n  (reset_n),
      .vld_in   (vld_p0),
      .data_in  (data_p0),
      .vld_out  (rvalid),
      .data_out (dout)
    );
  end else begin : g_direct
    assign rvalid = vld_p0;
    assign dout   = data_p0;
  end

endmodule
